// File: rtl/biquad_pkg.sv
// Shared constants, FSM state and MAC op encodings, and the saturation helper
// for the time-multiplexed biquad cascade.
package biquad_pkg;

    localparam int NCOEF = 5;
    localparam int B0 = 0;
    localparam int B1 = 1;
    localparam int B2 = 2;
    localparam int A1 = 3;
    localparam int A2 = 4;

    typedef enum logic [2:0] {IDLE, FB, FF, UPD, OUT} state_t;

    typedef enum logic [1:0] {MAC_INIT, MAC_ADD, MAC_SUB, MAC_LOAD} mac_op_t;

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared multiply-accumulate unit: one signed COEF_W x IO_W product per cycle
// folded into an ACC_W accumulator; acc_nxt exposes the value being written.
module biquad_mac
    import biquad_pkg::*;
#(
    parameter int IO_W   = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 14,
    parameter int ACC_W  = IO_W + COEF_W + 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  mac_op_t                  op,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [IO_W-1:0]   data,
    input  logic signed [IO_W-1:0]   ld,
    output logic signed [ACC_W-1:0]  acc,
    output logic signed [ACC_W-1:0]  acc_nxt
);

    logic signed [COEF_W+IO_W-1:0] prod;
    logic signed [ACC_W-1:0]       p_ext;
    logic signed [ACC_W-1:0]       ld_ext;

    assign prod   = coef * data;
    assign p_ext  = ACC_W'(prod);
    assign ld_ext = ACC_W'(ld) <<< FRAC;

    always_comb begin
        acc_nxt = acc;
        case (op)
            MAC_INIT: acc_nxt = p_ext;
            MAC_ADD:  acc_nxt = acc + p_ext;
            MAC_SUB:  acc_nxt = acc - p_ext;
            MAC_LOAD: acc_nxt = ld_ext - p_ext;
            default:  acc_nxt = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)   acc <= '0;
        else if (en) acc <= acc_nxt;
    end

endmodule

// File: rtl/biquad_cascade.sv
// N_STAGES DF-II biquads sharing one MAC, six cycles per section.
// Define BIQUAD_SAT_EN to clamp w/y and enable sat_flag; otherwise w/y wrap.
module biquad_cascade
    import biquad_pkg::*;
#(
    parameter int IO_W     = 16,
    parameter int COEF_W   = 16,
    parameter int FRAC     = 14,
    parameter int N_STAGES = 4,
    parameter int ACC_W    = IO_W + COEF_W + 3,
    localparam int AW      = $clog2(NCOEF * N_STAGES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     clear_state,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [IO_W-1:0]   s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [IO_W-1:0]   m_data,
    output logic                     busy,
    output logic                     sat_flag
);

    localparam int NC = NCOEF * N_STAGES;
    localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    state_t                   state, state_nxt;
    logic [1:0]               k;
    logic [SW-1:0]            stage;
    logic                     last;
    logic [AW-1:0]            cb;
    logic signed [IO_W-1:0]   x, w, w_new, y_new;
    logic signed [IO_W-1:0]   w1 [N_STAGES];
    logic signed [IO_W-1:0]   w2 [N_STAGES];
    logic signed [COEF_W-1:0] coef [NC];

    logic                     mac_en;
    mac_op_t                  mac_op;
    logic signed [COEF_W-1:0] mac_c;
    logic signed [IO_W-1:0]   mac_d;
    logic signed [ACC_W-1:0]  acc, acc_nxt;

    assign last    = (stage == SW'(N_STAGES - 1));
    assign cb      = AW'(NCOEF * int'(stage));
    assign s_ready = (state == IDLE) && !clear_state;
    assign busy    = (state != IDLE);

    biquad_mac #(.IO_W(IO_W), .COEF_W(COEF_W), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .reset   (reset),
        .en      (mac_en),
        .op      (mac_op),
        .coef    (mac_c),
        .data    (mac_d),
        .ld      (x),
        .acc     (acc),
        .acc_nxt (acc_nxt)
    );

    // Operand steering: FB builds w from x and the delay line, FF forms y from w.
    always_comb begin
        mac_en = 1'b0;
        mac_op = MAC_INIT;
        mac_c  = '0;
        mac_d  = '0;
        case (state)
            FB: begin
                mac_en = 1'b1;
                if (k == 2'd0) begin
                    mac_op = MAC_LOAD; mac_c = coef[cb + AW'(A1)]; mac_d = w1[stage];
                end else begin
                    mac_op = MAC_SUB;  mac_c = coef[cb + AW'(A2)]; mac_d = w2[stage];
                end
            end
            FF: begin
                mac_en = 1'b1;
                if (k == 2'd0) begin
                    mac_op = MAC_INIT; mac_c = coef[cb + AW'(B0)]; mac_d = w;
                end else if (k == 2'd1) begin
                    mac_op = MAC_ADD;  mac_c = coef[cb + AW'(B1)]; mac_d = w1[stage];
                end else begin
                    mac_op = MAC_ADD;  mac_c = coef[cb + AW'(B2)]; mac_d = w2[stage];
                end
            end
            default: ;
        endcase
    end

`ifdef BIQUAD_SAT_EN
    logic signed [63:0] w_full, w_sat, y_full, y_sat;
    logic               w_clip, y_clip;

    always_comb begin
        w_full = 64'(acc_nxt >>> FRAC);
        w_sat  = sat(w_full, IO_W);
        w_new  = IO_W'(w_sat);
        w_clip = (w_sat != w_full);
        y_full = 64'(acc >>> FRAC);
        y_sat  = sat(y_full, IO_W);
        y_new  = IO_W'(y_sat);
        y_clip = (y_sat != y_full);
    end

    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && clear_state))
            sat_flag <= 1'b0;
        else if ((state == FB && k == 2'd1 && w_clip) || (state == UPD && y_clip))
            sat_flag <= 1'b1;
    end
`else
    assign w_new    = IO_W'(acc_nxt >>> FRAC);
    assign y_new    = IO_W'(acc >>> FRAC);
    assign sat_flag = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (s_valid && !clear_state) state_nxt = FB;
            FB:   if (k == 2'd1) state_nxt = FF;
            FF:   if (k == 2'd2) state_nxt = UPD;
            UPD:  state_nxt = last ? OUT : FB;
            OUT:  if (m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NC; i++)
                coef[i] <= (i % NCOEF == B0) ? COEF_W'(2 ** FRAC) : '0;
        end else if (state == IDLE && coef_we && 32'(coef_addr) < NC) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            stage   <= '0;
            x       <= '0;
            w       <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            for (int i = 0; i < N_STAGES; i++) begin
                w1[i] <= '0;
                w2[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (clear_state) begin
                        for (int i = 0; i < N_STAGES; i++) begin
                            w1[i] <= '0;
                            w2[i] <= '0;
                        end
                    end else if (s_valid) begin
                        x     <= s_data;
                        stage <= '0;
                        k     <= '0;
                    end
                end
                FB: begin
                    if (k == 2'd0) begin
                        k <= 2'd1;
                    end else begin
                        k <= 2'd0;
                        w <= w_new;
                    end
                end
                FF: k <= (k == 2'd2) ? 2'd0 : k + 2'd1;
                UPD: begin
                    w2[stage] <= w1[stage];
                    w1[stage] <= w;
                    x         <= y_new;
                    if (last) begin
                        m_data  <= y_new;
                        m_valid <= 1'b1;
                    end else begin
                        stage <= stage + SW'(1);
                    end
                end
                OUT: if (m_ready) m_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_cascade.sv
// Scoreboard bench for biquad_cascade: directed impulses with hand-computed
// outputs, per-sample latency, stall, busy-write drop and mid-flight reset.
module tb_biquad_cascade;

    localparam int IO_W = 16;
    localparam int COEF_W = 16;
    localparam int N = 4;
    localparam int AW = $clog2(5 * N);
    localparam int LAT = 6 * N;

    logic clk = 1'b0;
    logic reset, coef_we, clear_state, s_valid, s_ready, m_valid, m_ready, busy, sat_flag;
    logic [AW-1:0] coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic signed [IO_W-1:0] s_data, m_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic signed [IO_W-1:0] exp_q[$];
    int acc_q[$];
    logic prev_mv = 1'b0;

    biquad_cascade #(.IO_W(IO_W), .COEF_W(COEF_W), .FRAC(14), .N_STAGES(N)) dut (
        .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .clear_state(clear_state), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: records accept edges, checks latency on m_valid rise and data on handshake.
    always @(negedge clk) begin
        int a;
        if (s_valid && s_ready) acc_q.push_back(cyc + 1);
        if (m_valid && !prev_mv) begin
            if (acc_q.size() == 0) chk("latency_no_accept", 1, 0);
            else begin
                a = acc_q.pop_front();
                chk("latency", cyc - a, LAT);
            end
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", int'(m_data), 0);
            else chk("m_data", int'(m_data), int'(exp_q.pop_front()));
        end
        prev_mv = m_valid;
    end

    task automatic send(input logic signed [IO_W-1:0] xv, input logic signed [IO_W-1:0] ev);
        int n = 0;
        s_data = xv;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("accept_timeout", 0, 1);
        exp_q.push_back(ev);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wcoef(input int addr, input int val);
        coef_we = 1'b1;
        coef_addr = AW'(addr);
        coef_wdata = COEF_W'(val);
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        acc_q.delete();
    endtask

    task automatic pulse_clear();
        clear_state = 1'b1;
        @(negedge clk);
        chk("s_ready_during_clear", int'(s_ready), 0);
        @(posedge clk); #1;
        clear_state = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        clear_state = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        @(posedge clk); #1;

        // Default coefficients pass samples through unchanged.
        send(1000, 1000); drain();
        send(-5, -5); drain();

        // y = 0.5*w + 0.5*w1 on stage 0.
        do_reset();
        wcoef(0, 8192); wcoef(1, 8192);
        send(1000, 500); drain();
        send(0, 500); drain();
        send(0, 0); drain();

        // w = x + 0.5*w1: geometric decay; then clear_state empties the delay line.
        do_reset();
        wcoef(3, -8192);
        send(1000, 1000); drain();
        send(0, 500); drain();
        send(0, 250); drain();
        send(0, 125); drain();
        pulse_clear();
        send(0, 0); drain();

        // 32767*32767 >>> 14 = 65532: clamps to 32767, or wraps to 0xFFFC = -4.
        do_reset();
        wcoef(0, 32767);
`ifdef BIQUAD_SAT_EN
        send(32767, 32767); drain();
        chk("sat_flag_set", int'(sat_flag), 1);
`else
        send(32767, -4); drain();
        chk("sat_flag_tied", int'(sat_flag), 0);
`endif
        pulse_clear();
        chk("sat_flag_cleared", int'(sat_flag), 0);

        // Output stall: data held, input ignored, next sample taken one cycle after OUT.
        do_reset();
        m_ready = 1'b0;
        send(111, 111);
        s_data = 222;
        s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("stall_m_valid", int'(m_valid), 1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_m_data", int'(m_data), 111);
            chk("stall_s_ready", int'(s_ready), 0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_out_s_ready", int'(s_ready), 1);
        chk("post_out_busy", int'(busy), 0);
        exp_q.push_back(222);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("accepted_busy", int'(busy), 1);
        drain();

        // Coefficient write while busy is dropped.
        do_reset();
        send(100, 100);
        wcoef(0, 0);
        drain();
        send(100, 100); drain();

        // Reset in the middle of stage 2 discards the sample and the coefficients.
        do_reset();
        wcoef(0, 8192);
        send(1000, 500);
        repeat (13) @(posedge clk);
        #1 do_reset();
        @(negedge clk);
        chk("midrst_m_valid", int'(m_valid), 0);
        chk("midrst_s_ready", int'(s_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        @(posedge clk); #1;
        send(1000, 1000); drain();

        repeat (3) @(posedge clk);
        if (acc_q.size() != 0) chk("leftover_accepts", acc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
